mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares a single memory port between the core's instruction-fetch requester and its load/store requester, so the datapath can run multi-cycle against one RAM. It sits between the fetch/LSU stages and the memory model, one transaction outstanding at a time. Data accesses win by default. A starvation counter forces a fetch grant after a bounded run of data grants. Responses are routed back to whichever requester owns the transaction.

## Interface
Parameters:
- ADDR_W, 64, address width on all ports.
- DATA_W, 64, data width on all ports; DATA_W/8 mask bits.
- STARVE_LIMIT, 4, maximum consecutive data grants while fetch is waiting; range 1..15.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request; held with if_addr stable until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_ready  out  1  one-cycle pulse: fetch request accepted.
- if_rvalid  out  1  one-cycle pulse: fetch data valid.
- if_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request; held with its payload stable until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_wmask  in  DATA_W/8  store byte enables.
- d_ready  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: load data valid or store complete.
- d_rdata  out  DATA_W  load data; 0 for stores.
- m_req  out  1  memory request; held until m_ready.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_wmask  out  DATA_W/8  memory byte enables.
- m_ready  in  1  memory accepts m_req this cycle.
- m_rvalid  in  1  memory response; required for both reads and writes.
- m_rdata  in  DATA_W  memory read data.
- err  out  1  sticky flag: m_rvalid seen outside RESP; cleared only by reset.

## Operation
- Three states:
  - IDLE: no transaction in flight.
  - REQ: drive the latched request on the memory port.
  - RESP: wait for the memory response.
- Owner register records which requester holds the transaction: IF or D.
- Arbitration in IDLE, decided combinationally from if_req and d_req:
  - d_req only: grant D.
  - if_req only: grant IF.
  - Both requesting: grant D if starve_cnt < STARVE_LIMIT, else grant IF.
- Grant action:
  - Pulse the winner's ready in the same cycle.
  - Latch its payload into the m_* registers and set owner.
  - Next state REQ.
  - Fetch payload latches with m_we=0, m_wdata=0, m_wmask=0.
- starve_cnt, 4 bits:
  - On a D grant while if_req=1: saturating increment.
  - On any IF grant: clear to 0.
  - Otherwise: hold.
- REQ: m_req=1 with registered payload. When m_ready=1, clear m_req and go to RESP. Payload holds until then.
- RESP: when m_rvalid=1:
  - Register the response to the owner on the next edge: owner rvalid=1; rdata=m_rdata for loads and fetches, 0 for stores.
  - Return to IDLE.
- The loser's request stays pending; it gets no ready pulse until granted.
- m_rvalid in IDLE or REQ: ignored and sets err. It is never routed to a requester.
- m_rvalid and m_ready together in REQ: accept only m_ready. m_rvalid is a protocol error and sets err.
- Reset mid-transaction:
  - State returns to IDLE; all outputs and starve_cnt go to 0.
  - The in-flight response is dropped.
  - Memory-side recovery is the memory model's responsibility.

## Timing
- Reset values are 0 for every output and register: if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata, m_req, m_we, m_addr, m_wdata, m_wmask, err, starve_cnt, owner. State resets to IDLE.
- Cycle 0: request seen in IDLE, ready pulses.
- Cycle 1: m_req=1.
- m_ready in cycle k ≥ 1 moves the arbiter to RESP at cycle k+1.
- m_rvalid in cycle j ≥ k+1 gives owner rvalid in cycle j+1, and the arbiter is in IDLE in cycle j+1.
- A new grant can occur in cycle j+1, the same cycle as the rvalid pulse.
- Minimum accept-to-rvalid latency: 3 cycles (m_ready in cycle 1, m_rvalid in cycle 2).
- ready and rvalid are exactly one cycle wide.
- At most one ready pulse per transaction; never both if_ready and d_ready in the same cycle.

## Test plan
- Single fetch:
  - Stimulus: if_req=1, if_addr=0x80000000; m_ready=1 in cycle 1; m_rvalid=1 with m_rdata=0x00000013 in cycle 2.
  - Response: if_ready in cycle 0; m_req=1 and m_we=0 in cycle 1; if_rvalid=1 with if_rdata=0x13 in cycle 3.
- Store:
  - Stimulus: d_req=1, d_we=1, d_addr=0x80001000, d_wdata=0x1122334455667788, d_wmask=0xFF; memory stalls m_ready for 3 cycles.
  - Response: m_req held 4 cycles with payload stable; d_rvalid=1 with d_rdata=0.
- Contention:
  - Stimulus: if_req and d_req held high continuously, STARVE_LIMIT=4.
  - Response: grant order D,D,D,D,IF, repeating; starve_cnt reads 4 on the IF grant cycle, then 0.
- Back-to-back:
  - Stimulus: d_req asserted in the same cycle as a fetch if_rvalid.
  - Response: d_ready in that same cycle.
- Errors:
  - Stimulus: m_rvalid pulse in IDLE.
  - Response: err=1 and stays 1; no rvalid to either requester; err clears only on reset.
- Reset mid-op:
  - Stimulus: assert reset while in RESP.
  - Response: all outputs 0 on the next edge; a later m_rvalid is not forwarded (it sets err once out of reset).

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/LSU requesters, the arbiter and the memory port.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    localparam int unsigned MASK_W = DATA_W / 8;

    // Instruction-fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    // Load/store requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [MASK_W-1:0] d_wmask;
    logic              d_ready;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // Shared memory port
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [MASK_W-1:0] m_wmask;
    logic              m_ready;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;

    // Sticky protocol error
    logic              err;

    // Arbiter side
    modport master (
        input  if_req, if_addr,
        output if_ready, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wmask,
        output d_ready, d_rvalid, d_rdata,
        output m_req, m_we, m_addr, m_wdata, m_wmask,
        input  m_ready, m_rvalid, m_rdata,
        output err
    );

    // Requester / memory-model side
    modport slave (
        output if_req, if_addr,
        input  if_ready, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wmask,
        input  d_ready, d_rvalid, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, m_wmask,
        output m_ready, m_rvalid, m_rdata,
        input  err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Data wins by default; a starvation counter forces a fetch grant after
// STARVE_LIMIT consecutive data grants while fetch waits. One transaction
// is outstanding at a time and its response returns to the owner.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                clock,
    input logic                reset,
    mem_port_arbiter_if.master bus
);
    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    state_t            state;
    state_t            state_nxt;
    owner_t            owner;
    logic [CNT_W-1:0]  starve_cnt;
    logic              grant_if;
    logic              grant_d;

    logic              m_req_q;
    logic              m_we_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic [MASK_W-1:0] m_wmask_q;
    logic              if_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic              d_rvalid_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              err_q;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and same-cycle grant decision
    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_d   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!reset) begin
                    if (bus.d_req && (!bus.if_req || (starve_cnt < LIMIT))) begin
                        grant_d = 1'b1;
                    end else if (bus.if_req) begin
                        grant_if = 1'b1;
                    end
                end
                if (grant_d || grant_if) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.m_ready) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.m_rvalid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the winner's payload onto the memory port; drop m_req on accept
    always_ff @(posedge clock) begin
        if (reset) begin
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wmask_q <= '0;
            owner     <= OWN_IF;
        end else if (grant_d) begin
            m_req_q   <= 1'b1;
            m_we_q    <= bus.d_we;
            m_addr_q  <= bus.d_addr;
            m_wdata_q <= bus.d_wdata;
            m_wmask_q <= bus.d_wmask;
            owner     <= OWN_D;
        end else if (grant_if) begin
            m_req_q   <= 1'b1;
            m_we_q    <= 1'b0;
            m_addr_q  <= bus.if_addr;
            m_wdata_q <= '0;
            m_wmask_q <= '0;
            owner     <= OWN_IF;
        end else if ((state == ST_REQ) && bus.m_ready) begin
            m_req_q   <= 1'b0;
        end
    end

    // Route the memory response to the owner as a one-cycle pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if ((state == ST_RESP) && bus.m_rvalid) begin
                if (owner == OWN_D) begin
                    d_rvalid_q <= 1'b1;
                    d_rdata_q  <= m_we_q ? '0 : bus.m_rdata;
                end else begin
                    if_rvalid_q <= 1'b1;
                    if_rdata_q  <= bus.m_rdata;
                end
            end
        end
    end

    // Sticky error on a response arriving outside the response phase
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (bus.m_rvalid && (state != ST_RESP)) begin
            err_q <= 1'b1;
        end
    end

    // Count data grants taken while fetch is waiting
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_d && bus.if_req && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign bus.if_ready  = grant_if;
    assign bus.d_ready   = grant_d;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.m_req     = m_req_q;
    assign bus.m_we      = m_we_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.m_wmask   = m_wmask_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand
// sequences for contention and reset, then random traffic against a
// transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int unsigned AW    = 64;
    localparam int unsigned DW    = 64;
    localparam int unsigned MW    = DW / 8;
    localparam int          LIMIT = 4;
    localparam int          NVEC  = 29;

    localparam logic [63:0] AF0 = 64'h0000_0000_8000_0000;
    localparam logic [63:0] AF1 = 64'h0000_0000_8000_0004;
    localparam logic [63:0] AS  = 64'h0000_0000_8000_1000;
    localparam logic [63:0] AL  = 64'h0000_0000_8000_2000;
    localparam logic [63:0] WD  = 64'h1122_3344_5566_7788;
    localparam logic [63:0] Z   = 64'h0;
    localparam logic [7:0]  MF  = 8'hFF;
    localparam logic [7:0]  M0  = 8'h00;
    localparam logic        L   = 1'b0;
    localparam logic        H   = 1'b1;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    typedef struct {
        logic        rst;
        logic        if_req;
        logic [63:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [63:0] d_addr;
        logic [63:0] d_wdata;
        logic [7:0]  d_wmask;
        logic        m_ready;
        logic        m_rvalid;
        logic [63:0] m_rdata;
    } in_t;

    typedef struct {
        logic        if_ready;
        logic        d_ready;
        logic        if_rvalid;
        logic [63:0] if_rdata;
        logic        d_rvalid;
        logic [63:0] d_rdata;
        logic        m_req;
        logic        m_we;
        logic [63:0] m_addr;
        logic [63:0] m_wdata;
        logic [7:0]  m_wmask;
        logic        err;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic in_t mk_in(input logic rst, input logic ifr, input logic [63:0] ifa,
                                  input logic dr, input logic dwe, input logic [63:0] da,
                                  input logic [63:0] dwd, input logic [7:0] dwm,
                                  input logic mr, input logic mv, input logic [63:0] md);
        in_t r;
        r.rst = rst; r.if_req = ifr; r.if_addr = ifa; r.d_req = dr; r.d_we = dwe;
        r.d_addr = da; r.d_wdata = dwd; r.d_wmask = dwm; r.m_ready = mr;
        r.m_rvalid = mv; r.m_rdata = md;
        return r;
    endfunction

    function automatic exp_t mk_ex(input logic ifrdy, input logic drdy, input logic ifv,
                                   input logic [63:0] ifd, input logic dv, input logic [63:0] dd,
                                   input logic mreq, input logic mwe, input logic [63:0] maddr,
                                   input logic [63:0] mwd, input logic [7:0] mwm, input logic er);
        exp_t r;
        r.if_ready = ifrdy; r.d_ready = drdy; r.if_rvalid = ifv; r.if_rdata = ifd;
        r.d_rvalid = dv; r.d_rdata = dd; r.m_req = mreq; r.m_we = mwe; r.m_addr = maddr;
        r.m_wdata = mwd; r.m_wmask = mwm; r.err = er;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_in(input in_t v);
        reset        = v.rst;
        bus.if_req   = v.if_req;
        bus.if_addr  = v.if_addr;
        bus.d_req    = v.d_req;
        bus.d_we     = v.d_we;
        bus.d_addr   = v.d_addr;
        bus.d_wdata  = v.d_wdata;
        bus.d_wmask  = v.d_wmask;
        bus.m_ready  = v.m_ready;
        bus.m_rvalid = v.m_rvalid;
        bus.m_rdata  = v.m_rdata;
    endtask

    task automatic drive_idle();
        apply_in(mk_in(L, L, Z, L, L, Z, Z, M0, L, L, Z));
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Directed per-cycle vectors
    task automatic run_table();
        in_t idle;
        idle = mk_in(L, L, Z, L, L, Z, Z, M0, L, L, Z);
        // reset gates a pending fetch; single fetch
        vecs[0]  = '{mk_in(H, H, AF0, L, L, Z, Z, M0, L, L, Z), mk_ex(L, L, L, Z, L, Z, L, L, Z, Z, M0, L)};
        vecs[1]  = '{mk_in(L, H, AF0, L, L, Z, Z, M0, L, L, Z), mk_ex(H, L, L, Z, L, Z, L, L, Z, Z, M0, L)};
        vecs[2]  = '{mk_in(L, L, Z, L, L, Z, Z, M0, H, L, Z),   mk_ex(L, L, L, Z, L, Z, H, L, AF0, Z, M0, L)};
        vecs[3]  = '{mk_in(L, L, Z, L, L, Z, Z, M0, L, H, 64'h13), mk_ex(L, L, L, Z, L, Z, L, L, Z, Z, M0, L)};
        vecs[4]  = '{idle, mk_ex(L, L, H, 64'h13, L, Z, L, L, Z, Z, M0, L)};
        // store with three stall cycles
        vecs[5]  = '{mk_in(L, L, Z, H, H, AS, WD, MF, L, L, Z), mk_ex(L, H, L, Z, L, Z, L, L, Z, Z, M0, L)};
        vecs[6]  = '{idle, mk_ex(L, L, L, Z, L, Z, H, H, AS, WD, MF, L)};
        vecs[7]  = '{idle, mk_ex(L, L, L, Z, L, Z, H, H, AS, WD, MF, L)};
        vecs[8]  = '{idle, mk_ex(L, L, L, Z, L, Z, H, H, AS, WD, MF, L)};
        vecs[9]  = '{mk_in(L, L, Z, L, L, Z, Z, M0, H, L, Z), mk_ex(L, L, L, Z, L, Z, H, H, AS, WD, MF, L)};
        vecs[10] = '{mk_in(L, L, Z, L, L, Z, Z, M0, L, H, 64'hDEAD), mk_ex(L, L, L, Z, L, Z, L, L, Z, Z, M0, L)};
        vecs[11] = '{idle, mk_ex(L, L, L, Z, H, Z, L, L, Z, Z, M0, L)};
        // fetch, then load granted in the fetch rvalid cycle
        vecs[12] = '{mk_in(L, H, AF1, L, L, Z, Z, M0, L, L, Z), mk_ex(H, L, L, Z, L, Z, L, L, Z, Z, M0, L)};
        vecs[13] = '{mk_in(L, L, Z, L, L, Z, Z, M0, H, L, Z),   mk_ex(L, L, L, Z, L, Z, H, L, AF1, Z, M0, L)};
        vecs[14] = '{mk_in(L, L, Z, L, L, Z, Z, M0, L, H, 64'h0010_0093), mk_ex(L, L, L, Z, L, Z, L, L, Z, Z, M0, L)};
        vecs[15] = '{mk_in(L, L, Z, H, L, AL, Z, M0, L, L, Z),  mk_ex(L, H, H, 64'h0010_0093, L, Z, L, L, Z, Z, M0, L)};
        vecs[16] = '{mk_in(L, L, Z, L, L, Z, Z, M0, H, L, Z),   mk_ex(L, L, L, Z, L, Z, H, L, AL, Z, M0, L)};
        vecs[17] = '{mk_in(L, L, Z, L, L, Z, Z, M0, L, H, 64'hCAFE_BABE_1234_5678), mk_ex(L, L, L, Z, L, Z, L, L, Z, Z, M0, L)};
        vecs[18] = '{idle, mk_ex(L, L, L, Z, H, 64'hCAFE_BABE_1234_5678, L, L, Z, Z, M0, L)};
        // stray response in IDLE: sticky err, cleared by reset
        vecs[19] = '{mk_in(L, L, Z, L, L, Z, Z, M0, L, H, 64'h99), mk_ex(L, L, L, Z, L, Z, L, L, Z, Z, M0, L)};
        vecs[20] = '{idle, mk_ex(L, L, L, Z, L, Z, L, L, Z, Z, M0, H)};
        vecs[21] = '{idle, mk_ex(L, L, L, Z, L, Z, L, L, Z, Z, M0, H)};
        vecs[22] = '{mk_in(H, L, Z, L, L, Z, Z, M0, L, L, Z), mk_ex(L, L, L, Z, L, Z, L, L, Z, Z, M0, H)};
        vecs[23] = '{idle, mk_ex(L, L, L, Z, L, Z, L, L, Z, Z, M0, L)};
        // m_ready and m_rvalid together in REQ: accept only, flag err
        vecs[24] = '{mk_in(L, H, AF0, L, L, Z, Z, M0, L, L, Z), mk_ex(H, L, L, Z, L, Z, L, L, Z, Z, M0, L)};
        vecs[25] = '{mk_in(L, L, Z, L, L, Z, Z, M0, H, H, 64'h5), mk_ex(L, L, L, Z, L, Z, H, L, AF0, Z, M0, L)};
        vecs[26] = '{idle, mk_ex(L, L, L, Z, L, Z, L, L, Z, Z, M0, H)};
        vecs[27] = '{mk_in(L, L, Z, L, L, Z, Z, M0, L, H, 64'h77), mk_ex(L, L, L, Z, L, Z, L, L, Z, Z, M0, H)};
        vecs[28] = '{idle, mk_ex(L, L, H, 64'h77, L, Z, L, L, Z, Z, M0, H)};

        for (int k = 0; k < NVEC; k++) begin
            apply_in(vecs[k].i);
            #2;
            chk($sformatf("v%0d if_ready", k),  64'(bus.if_ready),  64'(vecs[k].e.if_ready));
            chk($sformatf("v%0d d_ready", k),   64'(bus.d_ready),   64'(vecs[k].e.d_ready));
            chk($sformatf("v%0d if_rvalid", k), 64'(bus.if_rvalid), 64'(vecs[k].e.if_rvalid));
            chk($sformatf("v%0d d_rvalid", k),  64'(bus.d_rvalid),  64'(vecs[k].e.d_rvalid));
            chk($sformatf("v%0d m_req", k),     64'(bus.m_req),     64'(vecs[k].e.m_req));
            chk($sformatf("v%0d err", k),       64'(bus.err),       64'(vecs[k].e.err));
            if (vecs[k].e.if_rvalid)
                chk($sformatf("v%0d if_rdata", k), bus.if_rdata, vecs[k].e.if_rdata);
            if (vecs[k].e.d_rvalid)
                chk($sformatf("v%0d d_rdata", k), bus.d_rdata, vecs[k].e.d_rdata);
            if (vecs[k].e.m_req) begin
                chk($sformatf("v%0d m_we", k),    64'(bus.m_we),    64'(vecs[k].e.m_we));
                chk($sformatf("v%0d m_addr", k),  bus.m_addr,       vecs[k].e.m_addr);
                chk($sformatf("v%0d m_wdata", k), bus.m_wdata,      vecs[k].e.m_wdata);
                chk($sformatf("v%0d m_wmask", k), 64'(bus.m_wmask), 64'(vecs[k].e.m_wmask));
            end
            step();
        end
    endtask

    // Both requesters always asserted; memory answers at minimum latency
    task automatic run_contention();
        int   g = 0;
        logic prev_mreq = 1'b0;
        logic ifr, dr;
        logic [3:0] cnt;
        do_reset();
        for (int c = 0; c < 200 && g < 15; c++) begin
            bus.if_req   = 1'b1;
            bus.if_addr  = AF0 + 64'(c);
            bus.d_req    = 1'b1;
            bus.d_we     = 1'b0;
            bus.d_addr   = AL + 64'(c);
            bus.d_wdata  = Z;
            bus.d_wmask  = M0;
            bus.m_ready  = 1'b1;
            bus.m_rvalid = prev_mreq;
            bus.m_rdata  = 64'(c);
            #2;
            ifr = bus.if_ready;
            dr  = bus.d_ready;
            cnt = dut.starve_cnt;
            prev_mreq = bus.m_req;
            if (ifr || dr) begin
                chk($sformatf("cont grant%0d if_ready", g), 64'(ifr), 64'((g % (LIMIT + 1)) == LIMIT));
                chk($sformatf("cont grant%0d d_ready", g),  64'(dr),  64'((g % (LIMIT + 1)) != LIMIT));
                chk($sformatf("cont grant%0d starve_cnt", g), 64'(cnt), 64'(g % (LIMIT + 1)));
                g++;
            end
            step();
        end
        chk("cont grant count", 64'(g), 64'd15);
        chk("cont err", 64'(bus.err), 64'd0);
    endtask

    // Reset while waiting for a response drops that response
    task automatic run_reset_midop();
        do_reset();
        apply_in(mk_in(L, H, AF0, L, L, Z, Z, M0, L, L, Z));
        step();
        apply_in(mk_in(L, L, Z, L, L, Z, Z, M0, H, L, Z));
        step();
        apply_in(mk_in(H, L, Z, L, L, Z, Z, M0, L, L, Z));
        step();
        apply_in(mk_in(L, L, Z, L, L, Z, Z, M0, L, H, 64'h55));
        #2;
        chk("rst m_req",      64'(bus.m_req),      64'd0);
        chk("rst m_we",       64'(bus.m_we),       64'd0);
        chk("rst m_addr",     bus.m_addr,          Z);
        chk("rst m_wdata",    bus.m_wdata,         Z);
        chk("rst m_wmask",    64'(bus.m_wmask),    64'd0);
        chk("rst if_rvalid",  64'(bus.if_rvalid),  64'd0);
        chk("rst if_rdata",   bus.if_rdata,        Z);
        chk("rst d_rvalid",   64'(bus.d_rvalid),   64'd0);
        chk("rst d_rdata",    bus.d_rdata,         Z);
        chk("rst err",        64'(bus.err),        64'd0);
        chk("rst starve_cnt", 64'(dut.starve_cnt), 64'd0);
        step();
        drive_idle();
        #2;
        chk("post-rst if_rvalid", 64'(bus.if_rvalid), 64'd0);
        chk("post-rst d_rvalid",  64'(bus.d_rvalid),  64'd0);
        chk("post-rst err",       64'(bus.err),       64'd1);
        step();
    endtask

    // Random traffic against a transaction-level model
    task automatic run_random(input int ncyc);
        logic        f_act = 1'b0, d_act = 1'b0;
        logic [63:0] f_addr = Z, d_addr_r = Z, d_wdata_r = Z;
        logic [7:0]  d_wmask_r = M0;
        logic        d_we_r = 1'b0;
        logic        busy = 1'b0, accepted = 1'b0, own_d = 1'b0;
        logic        p_we = 1'b0;
        logic [63:0] p_addr = Z, p_wdata = Z;
        logic [7:0]  p_wmask = M0;
        logic        resp_due = 1'b0, resp_own_d = 1'b0;
        logic [63:0] resp_data = Z;
        logic        err_m = 1'b0;
        int          starve = 0;
        logic        exp_gd, exp_gf, mr, mv;
        logic [63:0] md;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            if (!f_act && ($urandom_range(0, 2) == 0)) begin
                f_act  = 1'b1;
                f_addr = {$urandom, $urandom};
            end
            if (!d_act && ($urandom_range(0, 1) == 0)) begin
                d_act     = 1'b1;
                d_we_r    = 1'($urandom_range(0, 1));
                d_addr_r  = {$urandom, $urandom};
                d_wdata_r = {$urandom, $urandom};
                d_wmask_r = 8'($urandom);
            end
            mr = 1'($urandom_range(0, 1));
            if (busy && accepted) mv = 1'($urandom_range(0, 1));
            else                  mv = (c >= ncyc / 2) && ($urandom_range(0, 39) == 0);
            md = {$urandom, $urandom};
            apply_in(mk_in(L, f_act, f_addr, d_act, d_we_r, d_addr_r, d_wdata_r, d_wmask_r, mr, mv, md));
            #2;
            exp_gd = !busy && d_act && (!f_act || (starve < LIMIT));
            exp_gf = !busy && f_act && !exp_gd;
            chk("rnd if_ready", 64'(bus.if_ready), 64'(exp_gf));
            chk("rnd d_ready",  64'(bus.d_ready),  64'(exp_gd));
            chk("rnd m_req",    64'(bus.m_req),    64'(busy && !accepted));
            if (busy && !accepted && mr) begin
                chk("rnd m_we",    64'(bus.m_we),    64'(p_we));
                chk("rnd m_addr",  bus.m_addr,       p_addr);
                chk("rnd m_wdata", bus.m_wdata,      p_wdata);
                chk("rnd m_wmask", 64'(bus.m_wmask), 64'(p_wmask));
            end
            chk("rnd if_rvalid", 64'(bus.if_rvalid), 64'(resp_due && !resp_own_d));
            chk("rnd d_rvalid",  64'(bus.d_rvalid),  64'(resp_due && resp_own_d));
            if (resp_due && resp_own_d)  chk("rnd d_rdata",  bus.d_rdata,  resp_data);
            if (resp_due && !resp_own_d) chk("rnd if_rdata", bus.if_rdata, resp_data);
            chk("rnd err", 64'(bus.err), 64'(err_m));

            resp_due = 1'b0;
            if (mv && !(busy && accepted)) err_m = 1'b1;
            if (busy && accepted && mv) begin
                resp_due   = 1'b1;
                resp_own_d = own_d;
                resp_data  = (own_d && p_we) ? Z : md;
                busy       = 1'b0;
            end else if (busy && !accepted && mr) begin
                accepted = 1'b1;
            end
            if (exp_gd) begin
                busy = 1'b1; accepted = 1'b0; own_d = 1'b1;
                p_we = d_we_r; p_addr = d_addr_r; p_wdata = d_wdata_r; p_wmask = d_wmask_r;
                d_act = 1'b0;
                if (f_act) starve = (starve < 15) ? starve + 1 : 15;
            end else if (exp_gf) begin
                busy = 1'b1; accepted = 1'b0; own_d = 1'b0;
                p_we = 1'b0; p_addr = f_addr; p_wdata = Z; p_wmask = M0;
                f_act = 1'b0;
                starve = 0;
            end
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        step();
        step();
        run_table();
        run_contention();
        run_reset_midop();
        run_random(4000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
